// File: rtl/gecko_divide_if.sv
// Command/result bus for the gecko_divide radix-2 divider.
// master: the issuing execute stage. slave: the divider.
interface gecko_divide_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [1:0]  cmd_type;
    logic [4:0]  cmd_addr;
    logic [2:0]  cmd_reg_status;
    logic        cmd_jump_flag;

    logic        result_valid;
    logic        result_ready;
    logic [4:0]  result_addr;
    logic [2:0]  result_reg_status;
    logic        result_jump_flag;
    logic [31:0] result_value;

    logic        busy;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_type, cmd_addr, cmd_reg_status, cmd_jump_flag,
        output result_ready,
        input  cmd_ready, result_valid, result_addr, result_reg_status, result_jump_flag,
        input  result_value, busy
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_type, cmd_addr, cmd_reg_status, cmd_jump_flag,
        input  result_ready,
        output cmd_ready, result_valid, result_addr, result_reg_status, result_jump_flag,
        output result_value, busy
    );
endinterface

// File: rtl/gecko_divide.sv
// gecko_divide: 32-bit riscv32 DIV/DIVU/REM/REMU unit.
// Restoring division on operand magnitudes, one quotient bit per clock over 32
// CALC cycles, followed by a sign fix and the divide-by-zero/overflow overrides.
// Optional macro GECKO_DIV_EARLY_OUT_EN: divide-by-zero and signed-overflow
// commands skip CALC and go straight to DONE with the forced result.
module gecko_divide (
    input logic           clk,
    input logic           rst,
    gecko_divide_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  count;
    logic [1:0]  op_type;
    logic [31:0] a_raw;
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic        ovf;
    logic [31:0] b_mag;
    logic [31:0] rem_reg;
    logic [31:0] quo_reg;

    logic [31:0] result_value;
    logic [4:0]  result_addr;
    logic [2:0]  result_reg_status;
    logic        result_jump_flag;

    // Type bit 0 selects unsigned, bit 1 selects remainder.
    logic        cmd_signed;
    logic        cmd_a_neg;
    logic        cmd_b_neg;
    logic        cmd_div_zero;
    logic        cmd_ovf;
    logic [31:0] cmd_a_mag;
    logic [31:0] cmd_b_mag;
    logic        early_out;

    assign cmd_signed   = ~bus.cmd_type[0];
    assign cmd_a_neg    = cmd_signed & bus.cmd_a[31];
    assign cmd_b_neg    = cmd_signed & bus.cmd_b[31];
    assign cmd_a_mag    = cmd_a_neg ? (32'd0 - bus.cmd_a) : bus.cmd_a;
    assign cmd_b_mag    = cmd_b_neg ? (32'd0 - bus.cmd_b) : bus.cmd_b;
    assign cmd_div_zero = (bus.cmd_b == 32'd0);
    assign cmd_ovf      = cmd_signed && (bus.cmd_a == 32'h8000_0000) && (bus.cmd_b == 32'hFFFF_FFFF);

`ifdef GECKO_DIV_EARLY_OUT_EN
    assign early_out = cmd_div_zero | cmd_ovf;
`else
    assign early_out = 1'b0;
`endif

    // Forced result for divide-by-zero (takes priority) and signed overflow.
    function automatic logic [31:0] special_value(input logic [1:0] op, input logic [31:0] a,
                                                  input logic zero);
        if (zero) begin
            return op[1] ? a : 32'hFFFF_FFFF;
        end
        return op[1] ? 32'h0000_0000 : 32'h8000_0000;
    endfunction

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        take;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] final_value;

    assign shifted  = {rem_reg, quo_reg[31]};
    assign take     = (shifted >= {1'b0, b_mag});
    assign diff     = shifted[31:0] - b_mag;
    assign rem_next = take ? diff : shifted[31:0];
    assign quo_next = {quo_reg[30:0], take};
    assign quo_fix  = (a_neg ^ b_neg) ? (32'd0 - quo_next) : quo_next;
    assign rem_fix  = a_neg ? (32'd0 - rem_next) : rem_next;
    assign final_value = (div_zero | ovf) ? special_value(op_type, a_raw, div_zero)
                                          : (op_type[1] ? rem_fix : quo_fix);

    // Control FSM, operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            count             <= 5'd0;
            op_type           <= 2'd0;
            a_raw             <= 32'd0;
            a_neg             <= 1'b0;
            b_neg             <= 1'b0;
            div_zero          <= 1'b0;
            ovf               <= 1'b0;
            b_mag             <= 32'd0;
            rem_reg           <= 32'd0;
            quo_reg           <= 32'd0;
            result_value      <= 32'd0;
            result_addr       <= 5'd0;
            result_reg_status <= 3'd0;
            result_jump_flag  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_type           <= bus.cmd_type;
                        a_raw             <= bus.cmd_a;
                        a_neg             <= cmd_a_neg;
                        b_neg             <= cmd_b_neg;
                        div_zero          <= cmd_div_zero;
                        ovf               <= cmd_ovf;
                        b_mag             <= cmd_b_mag;
                        rem_reg           <= 32'd0;
                        quo_reg           <= cmd_a_mag;
                        count             <= 5'd0;
                        result_addr       <= bus.cmd_addr;
                        result_reg_status <= bus.cmd_reg_status;
                        result_jump_flag  <= bus.cmd_jump_flag;
                        if (early_out) begin
                            result_value <= special_value(bus.cmd_type, bus.cmd_a, cmd_div_zero);
                            state        <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    count   <= count + 5'd1;
                    if (count == 5'd31) begin
                        result_value <= final_value;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.result_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready         = (state == ST_IDLE);
    assign bus.result_valid      = (state == ST_DONE);
    assign bus.busy              = (state != ST_IDLE);
    assign bus.result_value      = result_value;
    assign bus.result_addr       = result_addr;
    assign bus.result_reg_status = result_reg_status;
    assign bus.result_jump_flag  = result_jump_flag;

endmodule

// File: tb/tb_gecko_divide.sv
// Directed self-checking bench for gecko_divide.
// Honours GECKO_DIV_EARLY_OUT_EN for the expected latency of special cases.
module tb_gecko_divide;

    logic clk = 1'b0;
    logic rst;

    gecko_divide_if bus ();

    gecko_divide dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] T_DIV  = 2'd0;
    localparam logic [1:0] T_DIVU = 2'd1;
    localparam logic [1:0] T_REM  = 2'd2;
    localparam logic [1:0] T_REMU = 2'd3;

    localparam int LAT_FULL = 33;
`ifdef GECKO_DIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 1;
`else
    localparam int LAT_SPECIAL = 33;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Present one command at the falling edge; it is accepted at the next rising edge.
    task automatic start_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] addr, input logic [2:0] rs, input logic jf);
        @(negedge clk);
        bus.cmd_valid      = 1'b1;
        bus.cmd_type       = t;
        bus.cmd_a          = a;
        bus.cmd_b          = b;
        bus.cmd_addr       = addr;
        bus.cmd_reg_status = rs;
        bus.cmd_jump_flag  = jf;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Latency counts edges from the accept edge (1 = visible right after it).
    task automatic wait_result(output int lat);
        lat = 1;
        while (bus.result_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_a = 32'd0; bus.cmd_b = 32'd0;
        bus.cmd_addr = 5'd0; bus.cmd_reg_status = 3'd0; bus.cmd_jump_flag = 1'b0;
        bus.result_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset result_valid: got %b expected 0", bus.result_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset cmd_ready: got %b expected 1", bus.cmd_ready); end
        n_checks++; if (bus.result_value !== 32'd0) begin n_fail++; $display("[TB] FAIL reset result_value: got %h expected 0", bus.result_value); end
        n_checks++; if (bus.result_addr !== 5'd0 || bus.result_reg_status !== 3'd0 || bus.result_jump_flag !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset tags: got %h/%h/%b expected 0/0/0", bus.result_addr, bus.result_reg_status, bus.result_jump_flag);
        end
    endtask

    task automatic test_divu_remu();
        int lat;
        start_op(T_DIVU, 32'd100, 32'd7, 5'd5, 3'd3, 1'b1);
        n_checks++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL calc busy/ready: got %b/%b expected 1/0", bus.busy, bus.cmd_ready); end
        wait_result(lat);
        n_checks++; if (lat != LAT_FULL) begin n_fail++; $display("[TB] FAIL divu latency: got %0d expected %0d", lat, LAT_FULL); end
        n_checks++; if (bus.result_value !== 32'd14) begin n_fail++; $display("[TB] FAIL divu 100/7: got %h expected %h", bus.result_value, 32'd14); end
        n_checks++; if (bus.result_addr !== 5'd5 || bus.result_reg_status !== 3'd3 || bus.result_jump_flag !== 1'b1) begin
            n_fail++; $display("[TB] FAIL divu tags: got %h/%h/%b expected 05/3/1", bus.result_addr, bus.result_reg_status, bus.result_jump_flag);
        end
        take_result();
        n_checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL return idle: got ready %b busy %b expected 1/0", bus.cmd_ready, bus.busy); end
        start_op(T_REMU, 32'd100, 32'd7, 5'd6, 3'd1, 1'b0);
        wait_result(lat);
        n_checks++; if (lat != LAT_FULL) begin n_fail++; $display("[TB] FAIL remu latency: got %0d expected %0d", lat, LAT_FULL); end
        n_checks++; if (bus.result_value !== 32'd2) begin n_fail++; $display("[TB] FAIL remu 100/7: got %h expected %h", bus.result_value, 32'd2); end
        take_result();
    endtask

    task automatic test_signed();
        logic [1:0]  tv [6] = '{T_DIV, T_REM, T_DIV, T_REM, T_DIV, T_REM};
        logic [31:0] av [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FF9C, 32'hFFFF_FF9C};
        logic [31:0] bv [6] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] ev [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd14, 32'hFFFF_FFFE};
        int lat;
        for (int i = 0; i < 6; i++) begin
            start_op(tv[i], av[i], bv[i], 5'(i), 3'd0, 1'b0);
            wait_result(lat);
            n_checks++; if (lat != LAT_FULL) begin n_fail++; $display("[TB] FAIL signed latency #%0d: got %0d expected %0d", i, lat, LAT_FULL); end
            n_checks++; if (bus.result_value !== ev[i]) begin n_fail++; $display("[TB] FAIL signed #%0d %h/%h: got %h expected %h", i, av[i], bv[i], bus.result_value, ev[i]); end
            take_result();
        end
    endtask

    task automatic test_div_zero();
        logic [1:0]  tv [4] = '{T_DIVU, T_REMU, T_DIV, T_REM};
        logic [31:0] av [4] = '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        logic [31:0] ev [4] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(tv[i], av[i], 32'd0, 5'(20 + i), 3'd2, 1'b1);
            wait_result(lat);
            n_checks++; if (lat != LAT_SPECIAL) begin n_fail++; $display("[TB] FAIL div0 latency #%0d: got %0d expected %0d", i, lat, LAT_SPECIAL); end
            n_checks++; if (bus.result_value !== ev[i]) begin n_fail++; $display("[TB] FAIL div0 #%0d: got %h expected %h", i, bus.result_value, ev[i]); end
            n_checks++; if (bus.result_addr !== 5'(20 + i)) begin n_fail++; $display("[TB] FAIL div0 addr #%0d: got %h expected %h", i, bus.result_addr, 5'(20 + i)); end
            take_result();
        end
    endtask

    task automatic test_overflow();
        logic [1:0]  tv [4] = '{T_DIV, T_REM, T_DIVU, T_REMU};
        logic [31:0] ev [4] = '{32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000};
        int          lv [4] = '{LAT_SPECIAL, LAT_SPECIAL, LAT_FULL, LAT_FULL};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(tv[i], 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 3'd4, 1'b0);
            wait_result(lat);
            n_checks++; if (lat != lv[i]) begin n_fail++; $display("[TB] FAIL ovf latency #%0d: got %0d expected %0d", i, lat, lv[i]); end
            n_checks++; if (bus.result_value !== ev[i]) begin n_fail++; $display("[TB] FAIL ovf #%0d: got %h expected %h", i, bus.result_value, ev[i]); end
            take_result();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(T_DIVU, 32'd1000, 32'd10, 5'd17, 3'd6, 1'b0);
        wait_result(lat);
        n_checks++; if (lat != LAT_FULL) begin n_fail++; $display("[TB] FAIL bp latency: got %0d expected %0d", lat, LAT_FULL); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1; bus.cmd_type = T_DIVU; bus.cmd_a = 32'd9; bus.cmd_b = 32'd3; bus.cmd_addr = 5'd2;
            @(posedge clk);
            #1;
            n_checks++; if (bus.result_valid !== 1'b1 || bus.cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp hold %0d valid/ready: got %b/%b expected 1/0", i, bus.result_valid, bus.cmd_ready); end
            n_checks++; if (bus.result_value !== 32'd100 || bus.result_addr !== 5'd17 || bus.result_reg_status !== 3'd6) begin
                n_fail++; $display("[TB] FAIL bp hold %0d fields: got %h/%h/%h expected 64/11/6", i, bus.result_value, bus.result_addr, bus.result_reg_status);
            end
        end
        @(negedge clk);
        bus.cmd_valid    = 1'b0;
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
        n_checks++; if (bus.result_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL bp release: got valid %b ready %b busy %b expected 0/1/0", bus.result_valid, bus.cmd_ready, bus.busy);
        end
        @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp ignored cmd: got busy %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        int seen = 0;
        start_op(T_DIVU, 32'd1000, 32'd3, 5'd11, 3'd5, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL mid reset state: got valid %b busy %b ready %b expected 0/0/1", bus.result_valid, bus.busy, bus.cmd_ready);
        end
        n_checks++; if (bus.result_addr !== 5'd0 || bus.result_value !== 32'd0) begin
            n_fail++; $display("[TB] FAIL mid reset fields: got %h/%h expected 0/0", bus.result_addr, bus.result_value);
        end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.result_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("[TB] FAIL stray result after reset: got %0d cycles expected 0", seen); end
        start_op(T_DIVU, 32'd9, 32'd3, 5'd1, 3'd0, 1'b0);
        wait_result(lat);
        n_checks++; if (lat != LAT_FULL) begin n_fail++; $display("[TB] FAIL post reset latency: got %0d expected %0d", lat, LAT_FULL); end
        n_checks++; if (bus.result_value !== 32'd3) begin n_fail++; $display("[TB] FAIL post reset divu 9/3: got %h expected %h", bus.result_value, 32'd3); end
        take_result();
    endtask

    // Scenario sequence, then the summary line.
    initial begin
        test_reset();
        test_divu_remu();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so a stuck design still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/gecko_divide.md
GECKO_DIVIDE -- requirements
Module: gecko_divide

Interface
- REQ-001 Parameters: none; operand width fixed at 32 bits (riscv32 register value).
- REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
- REQ-003 rst  input  1  Synchronous, active-high reset, sampled on the rising edge of clk.
- REQ-004 cmd_valid  input  1  Divide command present.
- REQ-005 cmd_ready  output  1  Block can accept a command.
- REQ-006 cmd_a  input  32  Dividend (rs1 value).
- REQ-007 cmd_b  input  32  Divisor (rs2 value).
- REQ-008 cmd_type  input  2  Operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (gecko_execute_div_type_t encoding).
- REQ-009 cmd_addr, cmd_reg_status, cmd_jump_flag  input  5/3/1  Writeback tag fields, carried to the result unchanged.
- REQ-010 result_valid  output  1  Writeback result present.
- REQ-011 result_ready  input  1  Downstream accepts the result.
- REQ-012 result_addr, result_reg_status, result_jump_flag  output  5/3/1  Captured tag fields.
- REQ-013 result_value  output  32  Quotient or remainder.
- REQ-014 busy  output  1  High in any state other than IDLE.

Function
- REQ-015 FSM states: IDLE, CALC, DONE.
- REQ-016 cmd_ready shall be high only in IDLE; there is no same-cycle bypass from DONE.
- REQ-017 When cmd_valid && cmd_ready is seen at a clock edge, the block shall capture operands, type and tags, load iteration counter 0, and enter CALC (or DONE; see REQ-024).
- REQ-018 CALC: radix-2 restoring division on magnitudes, one quotient bit per cycle, for exactly 32 cycles; counter 0..31, wraps to DONE at 31.
- REQ-019 Magnitudes: for DIV/REM, operands with bit 31 set shall be two's-complement negated; DIVU/REMU use the raw operands.
- REQ-020 Sign fix for DIV: negate the quotient if sign(a) != sign(b).
- REQ-021 Sign fix for REM: negate the remainder if a is negative.
- REQ-022 Divide by zero shall force the result regardless of sign logic: DIV/DIVU quotient 0xFFFFFFFF, REM/REMU remainder equal to cmd_a.
- REQ-023 Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF) shall force quotient 0x80000000 and remainder 0.
- REQ-024 Latency without early-out: result_valid shall rise exactly 33 cycles after the accept edge.
- REQ-025 DONE: result_valid shall be high and all result fields shall be held stable until the result_valid && result_ready edge, then the FSM returns to IDLE.
- REQ-026 The earliest next accept is the cycle after the result handshake; throughput is 1 op per 34 cycles minimum.
- REQ-027 cmd_* inputs shall be ignored outside IDLE.

Reset
- REQ-028 On rst, the block shall go to IDLE with result_valid=0, busy=0, cmd_ready=1, result_value=0, result tags=0, and counter=0.
- REQ-029 Reset asserted during CALC or DONE shall discard the in-flight operation; no result_valid pulse follows reset.

Configuration
- REQ-030 Macro GECKO_DIV_EARLY_OUT_EN.
  - Defined: divide-by-zero and signed-overflow commands skip CALC and enter DONE directly, so result_valid is high 1 cycle after the accept edge.
  - Undefined: all commands take 32 CALC cycles (REQ-024).
  - Result values are identical in both builds.

Verification
- REQ-031 DIVU a=100 b=7, tag addr=5 -> after 33 cycles result_value=14, result_addr=5; REMU same operands -> 2.
- REQ-032 DIV a=-7 (0xFFFFFFF9) b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
- REQ-033 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV -5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB. Check 1-cycle latency with GECKO_DIV_EARLY_OUT_EN defined and 33-cycle latency without it.
- REQ-034 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- REQ-035 Backpressure: hold result_ready=0 for 10 cycles in DONE -> result fields stable, cmd_ready=0, a new cmd_valid is not accepted; release -> IDLE next cycle.
- REQ-036 Assert rst at CALC cycle 12 -> next cycle IDLE, result_valid=0, busy=0; a following DIVU 9/3 -> 3.
